// File: rtl/shift_add_pkg.sv
// shift_add_pkg: FSM encodings and shared helpers for the shift-add scaler family.
package shift_add_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

    function automatic int acc_width(input int width, input int nterms);
        return width + $clog2(nterms) + 1;
    endfunction

    // Helpers work on a 64-bit carrier so any block with acc width <= 64 can share them
    function automatic logic out_of_range(input logic signed [63:0] v, input int w);
        return v > ((64'sd1 <<< (w - 1)) - 64'sd1) || v < -(64'sd1 <<< (w - 1));
    endfunction

    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return v > hi ? hi : v < lo ? lo : v;
    endfunction
endpackage

// File: rtl/shift_add_term.sv
// shift_add_term: one signed shift-add term (+/- x>>>shift, or 0 when disabled) at accumulator width.
module shift_add_term #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int AW    = 36
) (
    input  logic [WIDTH-1:0] x,
    input  logic [SHW-1:0]   shift,
    input  logic             sign,
    input  logic             en,
    output logic [AW-1:0]    term
);
    logic signed [AW-1:0] xe, sh;

    // Extending first keeps large shifts sign-filled to 0 / -1
    assign xe   = {{(AW - WIDTH){x[WIDTH-1]}}, x};
    assign sh   = xe >>> shift;
    assign term = !en ? '0 : sign ? -sh : sh;
endmodule

// File: rtl/shift_add_scaler_seq.sv
// shift_add_scaler_seq: multi-cycle programmable shift-add scaler, one term per cycle,
// with guard-bit accumulation, optional saturation and valid/ready handshakes.
module shift_add_scaler_seq
    import shift_add_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NTERMS = 4,
    parameter int SHW    = 5,
    parameter int SAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      data_i,
    input  logic [NTERMS*SHW-1:0] coef_shift_i,
    input  logic [NTERMS-1:0]     coef_sign_i,
    input  logic [NTERMS-1:0]     coef_en_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      data_o,
    output logic                  overflow_o
);
    localparam int AW = acc_width(WIDTH, NTERMS);
    localparam int IW = NTERMS > 1 ? $clog2(NTERMS) : 1;

    state_t                state;
    logic [WIDTH-1:0]      x_r;
    logic [NTERMS*SHW-1:0] shift_r;
    logic [NTERMS-1:0]     sign_r, en_r;
    logic [IW-1:0]         idx;
    logic signed [AW-1:0]  acc, acc_nxt;
    logic [AW-1:0]         term;
    logic signed [63:0]    acc_ext, sat_v;
    logic [WIDTH-1:0]      fit_d;
    logic                  ovf_d;

    shift_add_term #(.WIDTH(WIDTH), .SHW(SHW), .AW(AW)) u_term (
        .x    (x_r),
        .shift(shift_r[idx*SHW +: SHW]),
        .sign (sign_r[idx]),
        .en   (en_r[idx]),
        .term (term)
    );

    assign acc_nxt  = acc + $signed(term);
    assign acc_ext  = 64'(acc_nxt);
    assign sat_v    = sat_clamp(acc_ext, WIDTH);
    assign ovf_d    = out_of_range(acc_ext, WIDTH);
    assign fit_d    = SAT != 0 ? WIDTH'(sat_v) : WIDTH'(acc_nxt);
    assign in_ready = state == S_IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            x_r        <= '0;
            shift_r    <= '0;
            sign_r     <= '0;
            en_r       <= '0;
            idx        <= '0;
            acc        <= '0;
            out_valid  <= 1'b0;
            data_o     <= '0;
            overflow_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    x_r     <= data_i;
                    shift_r <= coef_shift_i;
                    sign_r  <= coef_sign_i;
                    en_r    <= coef_en_i;
                    acc     <= '0;
                    idx     <= '0;
                    state   <= S_ACC;
                end
                S_ACC: begin
                    acc <= acc_nxt;
                    idx <= idx + IW'(1);
                    if (idx == IW'(NTERMS - 1)) begin
                        data_o     <= fit_d;
                        overflow_o <= ovf_d;
                        out_valid  <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_scaler_seq.sv
// tb_shift_add_scaler_seq: randomized + directed check of the scaler (SAT=1 and SAT=0 instances)
// against an arithmetic reference model.
module tb_shift_add_scaler_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] data_i = '0;
    logic [19:0] coef_shift_i = '0;
    logic [3:0]  coef_sign_i = '0;
    logic [3:0]  coef_en_i = '0;
    logic        in_ready, out_valid, overflow_o;
    logic [31:0] data_o;
    logic        in_ready_w, out_valid_w, overflow_o_w;
    logic [31:0] data_o_w;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    shift_add_scaler_seq #(.WIDTH(32), .NTERMS(4), .SHW(5), .SAT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_i(data_i),
        .coef_shift_i(coef_shift_i), .coef_sign_i(coef_sign_i), .coef_en_i(coef_en_i),
        .out_valid(out_valid), .out_ready(out_ready), .data_o(data_o), .overflow_o(overflow_o)
    );

    shift_add_scaler_seq #(.WIDTH(32), .NTERMS(4), .SHW(5), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .data_i(data_i),
        .coef_shift_i(coef_shift_i), .coef_sign_i(coef_sign_i), .coef_en_i(coef_en_i),
        .out_valid(out_valid_w), .out_ready(out_ready), .data_o(data_o_w), .overflow_o(overflow_o_w)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // y = sum of enabled (+/-) floor(x / 2^shift), in plain 64-bit arithmetic
    function automatic longint ref_sum(input logic [31:0] x, input logic [19:0] sh,
                                       input logic [3:0] sg, input logic [3:0] en);
        longint s = 0;
        longint xs = longint'($signed(x));
        longint t;
        for (int k = 0; k < 4; k++)
            if (en[k]) begin
                t = xs >>> sh[k*5 +: 5];
                s = sg[k] ? s - t : s + t;
            end
        return s;
    endfunction

    function automatic logic ovf32(input longint s);
        return s > 64'sd2147483647 || s < -64'sd2147483648;
    endfunction

    function automatic logic [31:0] sat32(input longint s);
        return s > 64'sd2147483647 ? 32'h7FFFFFFF : s < -64'sd2147483648 ? 32'h80000000 : s[31:0];
    endfunction

    function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
        return {d[4:0], c[4:0], b[4:0], a[4:0]};
    endfunction

    task automatic check_result(input string tag, input longint s);
        chk({tag, "_sat"}, data_o, sat32(s));
        chk({tag, "_wrap"}, data_o_w, s[31:0]);
        chk({tag, "_ovf"}, overflow_o, ovf32(s));
        chk({tag, "_ovf_w"}, overflow_o_w, ovf32(s));
    endtask

    task automatic run_op(input logic [31:0] x, input logic [19:0] sh, input logic [3:0] sg,
                          input logic [3:0] en, input int stall);
        int n;
        longint s;
        logic [31:0] hold;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk("in_ready", in_ready, 1);
        s = ref_sum(x, sh, sg, en);
        data_i = x; coef_shift_i = sh; coef_sign_i = sg; coef_en_i = en; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_i = $urandom; coef_shift_i = 20'($urandom); coef_sign_i = 4'($urandom); coef_en_i = 4'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("latency", 64'(n), 4);
        chk("out_valid_w", out_valid_w, 1);
        check_result("op", s);
        hold = data_o;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            data_i = $urandom;
            @(posedge clk); #1;
            chk("hold_data", data_o, hold);
            chk("hold_valid", out_valid, 1);
            chk("busy", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release", out_valid, 0);
        chk("idle", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint q[$];
        longint s;
        int last_acc, n;
        logic acc_now;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data", data_o, 0);
        chk("rst_ovf", overflow_o, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_op(32'd160, pk(0, 4, 0, 0), 4'b0000, 4'b0011, 0);
        run_op(-32'sd160, pk(0, 4, 0, 0), 4'b0000, 4'b0011, 1);
        run_op(32'd100, pk(0, 2, 0, 0), 4'b0010, 4'b0011, 0);
        run_op(32'hFFFFFFFF, pk(31, 0, 0, 0), 4'b0000, 4'b0001, 0);
        run_op(32'h7FFFFFFF, pk(0, 0, 0, 0), 4'b0000, 4'b0011, 0);
        run_op(32'h80000000, pk(0, 0, 0, 0), 4'b0000, 4'b0011, 2);
        run_op(32'h80000000, pk(0, 0, 0, 0), 4'b0001, 4'b0001, 0);
        run_op($urandom, 20'($urandom), 4'($urandom), 4'b0000, 0);
        run_op(32'h12345678, pk(1, 3, 5, 7), 4'b1010, 4'b1111, 5);

        // Asynchronous reset in the second ACC cycle
        data_i = 32'd1000; coef_shift_i = pk(0, 1, 2, 3); coef_sign_i = 0; coef_en_i = 4'b1111; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        #1 rst = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_data", data_o, 0);
        chk("arst_data_w", data_o_w, 0);
        chk("arst_in_ready", in_ready, 1);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        run_op(32'd1000, pk(0, 1, 2, 3), 4'b0000, 4'b1111, 0);

        for (int i = 0; i < 25; i++)
            run_op(i % 3 == 0 ? {1'b0, {31{1'b1}}} ^ 32'($urandom_range(0, 255)) : $urandom,
                   20'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 3));

        // Back-to-back: in_valid held, out_ready high
        out_ready = 1'b1;
        in_valid = 1'b1;
        data_i = $urandom; coef_shift_i = 20'($urandom); coef_sign_i = 4'($urandom); coef_en_i = 4'($urandom);
        last_acc = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            acc_now = in_ready;
            if (acc_now) q.push_back(ref_sum(data_i, coef_shift_i, coef_sign_i, coef_en_i));
            if (out_valid) begin
                chk("b2b_order", q.size() > 0, 1);
                if (q.size() > 0) begin s = q.pop_front(); check_result("b2b", s); end
            end
            @(posedge clk); #1;
            if (acc_now) begin
                if (last_acc >= 0) chk("b2b_gap", 64'(cyc - last_acc), 6);
                last_acc = cyc;
                data_i = $urandom; coef_shift_i = 20'($urandom); coef_sign_i = 4'($urandom); coef_en_i = 4'($urandom);
            end
        end
        in_valid = 1'b0;
        n = 0;
        while (q.size() > 0 && n < 20) begin
            if (out_valid) begin s = q.pop_front(); check_result("b2b_drain", s); end
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_left", 64'(q.size()), 0);
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
